joy_dir_filter: RTL and testbench

Multi-player joystick direction conditioner between the input mux (USB/DB9/DB15) and the game core. It replaces the single-player, single-mode one-direction filter. Per player it provides:
- two-flop input synchronisation
- per-bit debounce
- one of four runtime-selectable direction modes: passthrough, 4-way last-pressed, 4-way first-held, 8-way with opposite-direction cancel (SOCD neutral)

Direction vectors are 4 bits per player, ordered {up, down, left, right} = bits [3:0].

---
 rtl/joy_dir_filter.sv | 149 ++++++++++++++
 tb/tb_joy_dir_filter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction conditioner.
// Per player: two-flop sync, per-bit debounce, then one of four direction
// modes (passthrough, 4-way last-pressed, 4-way first-held, 8-way SOCD
// neutral). Direction nibble order is {up, down, left, right} = [3:0].
// state_dbg exposes each player's lock state (3 bits per player) for checkers.
module joy_dir_filter #(
  parameter int PLAYERS = 2,
  parameter int DB_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic [1:0]           mode,
  input  logic [DB_W-1:0]      db_len,
  input  logic [4*PLAYERS-1:0] indir,
  output logic [4*PLAYERS-1:0] outdir,
  output logic [PLAYERS-1:0]   changed,
  output logic [3*PLAYERS-1:0] state_dbg
);

  // Bit 2 = locked, bits [1:0] = locked direction index.
  typedef enum logic [2:0] {
    ST_FREE   = 3'b000,
    ST_LOCK_R = 3'b100,
    ST_LOCK_L = 3'b101,
    ST_LOCK_D = 3'b110,
    ST_LOCK_U = 3'b111
  } lock_state_t;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_LAST = 2'd1;
  localparam logic [1:0] MODE_HOLD = 2'd2;
  localparam logic [1:0] MODE_SOCD = 2'd3;

  // Highest-priority set bit: up > down > left > right.
  function automatic logic [1:0] prio_bit(input logic [3:0] v);
    if (v[3])      prio_bit = 2'd3;
    else if (v[2]) prio_bit = 2'd2;
    else if (v[1]) prio_bit = 2'd1;
    else           prio_bit = 2'd0;
  endfunction

  function automatic lock_state_t lock_to(input logic [1:0] d);
    lock_to = lock_state_t'({1'b1, d});
  endfunction

  logic [1:0] mode_q;
  logic       mode_switch;

  assign mode_switch = (mode != mode_q);

  // Mode register; also loaded during reset so release never looks like a switch.
  always_ff @(posedge clk) begin
    mode_q <= mode;
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0]      s1, s2, db, db_prev, rise;
    logic [3:0]      out_q, out_n;
    logic            chg_q;
    logic [DB_W-1:0] cnt [4];
    lock_state_t     state, state_n, fallback;
    logic            held;

    // Next lock state and next output for this player.
    always_comb begin
      rise     = db & ~db_prev;
      held     = state[2] && db[state[1:0]];
      fallback = (db != 4'b0000) ? lock_to(prio_bit(db)) : ST_FREE;
      state_n  = ST_FREE;
      out_n    = 4'b0000;
      case (mode_q)
        MODE_PASS: begin
          state_n = ST_FREE;
          out_n   = db;
        end
        MODE_LAST: begin
          if (rise != 4'b0000) state_n = lock_to(prio_bit(rise));
          else if (held)       state_n = state;
          else if (state[2])   state_n = fallback;
          else                 state_n = ST_FREE;
          out_n = state_n[2] ? (4'b0001 << state_n[1:0]) : 4'b0000;
        end
        MODE_HOLD: begin
          // A held lock ignores rises; otherwise (free or released) take the top held bit.
          state_n = held ? state : fallback;
          out_n   = state_n[2] ? (4'b0001 << state_n[1:0]) : 4'b0000;
        end
        MODE_SOCD: begin
          state_n = ST_FREE;
          out_n   = {(db[3] ^ db[2]) ? db[3:2] : 2'b00,
                     (db[1] ^ db[0]) ? db[1:0] : 2'b00};
        end
      endcase
      if (mode_switch) begin
        state_n = ST_FREE;
        out_n   = 4'b0000;
      end
    end

    // Input synchronisation and per-bit debounce.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        s1      <= 4'b0000;
        s2      <= 4'b0000;
        db      <= 4'b0000;
        db_prev <= 4'b0000;
        for (int b = 0; b < 4; b++) cnt[b] <= '0;
      end else begin
        s1      <= indir[4*p +: 4];
        s2      <= s1;
        db_prev <= db;
        for (int b = 0; b < 4; b++) begin
          if (s2[b] == db[b]) begin
            cnt[b] <= '0;
          end else if (db_len == '0) begin
            db[b]  <= s2[b];
            cnt[b] <= '0;
          end else if (ce) begin
            if (cnt[b] == db_len - 1'b1) begin
              db[b]  <= s2[b];
              cnt[b] <= '0;
            end else begin
              cnt[b] <= cnt[b] + 1'b1;
            end
          end
        end
      end
    end

    // Lock FSM with registered direction output and change pulse.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state <= ST_FREE;
        out_q <= 4'b0000;
        chg_q <= 1'b0;
      end else begin
        state <= state_n;
        out_q <= out_n;
        chg_q <= (out_n != out_q);
      end
    end

    assign outdir[4*p +: 4]    = out_q;
    assign changed[p]          = chg_q;
    assign state_dbg[3*p +: 3] = state;
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Directed bench for joy_dir_filter (PLAYERS = 2, DB_W = 8).
module tb_joy_dir_filter;

  localparam int PLAYERS = 2;
  localparam int DB_W    = 8;

  logic                 clk;
  logic                 reset_n;
  logic                 ce;
  logic [1:0]           mode;
  logic [DB_W-1:0]      db_len;
  logic [4*PLAYERS-1:0] indir;
  logic [4*PLAYERS-1:0] outdir;
  logic [PLAYERS-1:0]   changed;
  logic [3*PLAYERS-1:0] state_dbg;

  int tests;
  int failed;
  int ce_phase;

  joy_dir_filter #(.PLAYERS(PLAYERS), .DB_W(DB_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .mode      (mode),
    .db_len    (db_len),
    .indir     (indir),
    .outdir    (outdir),
    .changed   (changed),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clocks; return 1 time unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance n clocks with a one-cycle ce strobe every 4 clocks.
  task automatic run_ce(input int n);
    for (int i = 0; i < n; i++) begin
      ce = (ce_phase == 0);
      ce_phase = (ce_phase + 1) % 4;
      tick(1);
    end
    ce = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic settle(input logic [7:0] v);
    indir = v;
    tick(5);
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    ce_phase = 0;
    reset_n  = 1'b0;
    ce       = 1'b0;
    mode     = 2'd0;
    db_len   = '0;
    indir    = 8'hFF;

    // Reset
    tick(2);
    check("reset_out", 32'(outdir), 32'h00);
    check("reset_chg", 32'(changed), 32'h0);
    indir = 8'h00;
    tick(1);
    reset_n = 1'b1;
    tick(5);
    check("idle_out", 32'(outdir), 32'h00);

    // Passthrough latency: 4 clk from input to output
    indir = 8'h5A;
    tick(3);
    check("pass_early", 32'(outdir), 32'h00);
    tick(1);
    check("pass_out", 32'(outdir), 32'h5A);
    check("pass_chg", 32'(changed), 32'h3);
    tick(1);
    check("pass_chg_off", 32'(changed), 32'h0);
    check("pass_hold", 32'(outdir), 32'h5A);

    // Mode 1: last-pressed
    settle(8'h00);
    mode = 2'd1;
    tick(2);
    settle(8'h01);
    check("m1_right", 32'(outdir), 32'h01);
    settle(8'h09);
    check("m1_add_up", 32'(outdir), 32'h08);
    settle(8'h01);
    check("m1_rel_up", 32'(outdir), 32'h01);
    settle(8'h00);
    check("m1_rel_all", 32'(outdir), 32'h00);
    settle(8'h0A);
    check("m1_up_left", 32'(outdir), 32'h08);

    // Mode 2: first-held
    settle(8'h00);
    mode = 2'd2;
    tick(2);
    settle(8'h02);
    check("m2_left", 32'(outdir), 32'h02);
    settle(8'h06);
    check("m2_add_down", 32'(outdir), 32'h02);
    settle(8'h04);
    check("m2_rel_left", 32'(outdir), 32'h04);

    // Mode 3: SOCD neutral
    mode = 2'd3;
    tick(2);
    settle(8'h0D);
    check("m3_1101", 32'(outdir), 32'h01);
    settle(8'h0F);
    check("m3_1111", 32'(outdir), 32'h00);
    settle(8'h09);
    check("m3_1001", 32'(outdir), 32'h09);

    // Debounce: db_len = 3, ce every 4 clk
    settle(8'h00);
    mode = 2'd0;
    tick(2);
    db_len = 8'd3;
    tick(1);
    ce_phase = 0;
    indir = 8'h08;
    run_ce(8);
    check("db_pulse_mid", 32'(outdir), 32'h00);
    indir = 8'h00;
    run_ce(16);
    check("db_pulse_out", 32'(outdir), 32'h00);
    ce_phase = 0;
    indir = 8'h08;
    run_ce(13);
    check("db_press_early", 32'(outdir), 32'h00);
    run_ce(1);
    check("db_press_out", 32'(outdir), 32'h08);
    check("db_press_chg", 32'(changed), 32'h1);
    db_len = '0;
    settle(8'h00);
    check("db_release", 32'(outdir), 32'h00);

    // Mode change 1 -> 2 with both players holding
    mode = 2'd1;
    tick(2);
    settle(8'h48);
    check("mc_m1_out", 32'(outdir), 32'h48);
    mode = 2'd2;
    tick(1);
    check("mc_switch_out", 32'(outdir), 32'h00);
    tick(1);
    check("mc_m2_out", 32'(outdir), 32'h48);

    // Reset pulse mid-press
    reset_n = 1'b0;
    tick(1);
    check("rst_mid_out", 32'(outdir), 32'h00);
    check("rst_mid_chg", 32'(changed), 32'h0);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      check($sformatf("rst_rel_out%0d", i), 32'(outdir), 32'h00);
      check($sformatf("rst_rel_chg%0d", i), 32'(changed), 32'h0);
    end
    tick(1);
    check("rst_rel_back", 32'(outdir), 32'h48);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
